aftab_dawu_multilane: RTL and testbench
=======================================

# aftab_dawu_multilane

Parametrised data-adjustment write unit for the AFTAB datapath. It accepts one store request (address, data, size) from the core and issues it to a data memory whose bus is `MEM_BYTES` bytes wide. The store is split into as many memory beats as the address alignment requires, with byte enables and lane-steered data on each beat. It replaces the fixed byte-serial write unit and adds wide buses, misalignment splitting/trapping and a busy indication.

## Interface
- `XLEN`, default 32: core data/address width; store sizes up to `XLEN/8` bytes.
- `MEM_BYTES`, default 4: memory data bus width in bytes; legal values are 1, 2 and 4.
- `ALLOW_MISALIGNED`, default 1: 1 splits misaligned stores into beats; 0 rejects them with `misaligned`.
- `clk  in  1`: clock.
- `rst  in  1`: reset, asynchronous, active-high.
- `startDAWU  in  1`: request strobe; honoured only in IDLE.
- `addrIn  in  XLEN`: byte address of the store.
- `dataIn  in  XLEN`: store data, right-aligned (byte 0 = LSB).
- `sizeIn  in  2`: number of bytes. 00 = 1, 01 = 2, 10 = 4, 11 = reserved and treated as 4.
- `memRdy  in  1`: memory accepted the current beat (sampled on the rising edge).
- `memAddr  out  XLEN`: beat address, aligned to `MEM_BYTES`.
- `memDataOut  out  8*MEM_BYTES`: lane-steered write data.
- `memByteEn  out  MEM_BYTES`: active lanes for the beat.
- `writeMem  out  1`: beat valid.
- `busy  out  1`: high while the unit is not in IDLE.
- `completeDAWU  out  1`: high in the cycle the final beat is accepted.
- `misaligned  out  1`: rejected-request pulse.

## Operation
- States:
  - IDLE: waits for a request. A start with a legal request goes to WRITE; a rejected start stays in IDLE.
  - WRITE: issues beats. It returns to IDLE when `memRdy` is high and the remaining count after the current beat is 0.
- Start in IDLE loads the internal registers:
  - `addrR = addrIn`, `dataR = dataIn`, `remR = size`.
- Per beat:
  - `off = addrR mod MEM_BYTES`.
  - `n = min(remR, MEM_BYTES - off)`.
  - `memAddr = addrR` with its low `log2(MEM_BYTES)` bits cleared.
  - `memByteEn` bits `off .. off+n-1` are set.
  - Lane k carries byte `k-off` of `dataR`; unused lanes drive 0.
- On `memRdy` in WRITE:
  - `addrR += n`, `dataR >>= 8*n`, `remR -= n`.
  - Address arithmetic wraps modulo 2^XLEN.
- `memAddr`, `memDataOut` and `memByteEn` hold stable while `writeMem` is high and `memRdy` is low.
- `misaligned` = `startDAWU` & IDLE & `ALLOW_MISALIGNED`==0 & (`addrIn mod size` != 0). It is combinational and produces no beats and no `completeDAWU`.
- `startDAWU` while busy is ignored; no queueing.
- `memRdy` in IDLE is ignored.
- Size larger than `MEM_BYTES` is always split, regardless of `ALLOW_MISALIGNED`.

## Timing
- Reset value: state = IDLE; `addrR`, `dataR` and `remR` are 0. All outputs read 0: `writeMem`, `busy`, `completeDAWU`, `misaligned`, `memByteEn`, `memAddr`, `memDataOut`.
- Assertion of `rst` mid-WRITE aborts immediately. Outputs drop to 0 asynchronously, and no further beats are issued after release.
- Start is accepted in cycle 0. `writeMem` first goes high in cycle 1.
- With `memRdy` tied high, a B-beat store occupies cycles 1..B. `completeDAWU` is high in cycle B, and IDLE is reached in cycle B+1.
- A new start may be presented in cycle B+1, giving back-to-back throughput of B+1 cycles per store.
- Each cycle with `memRdy` low in WRITE adds one cycle of latency.
- `completeDAWU` and `misaligned` are single-cycle and combinational from state and inputs.
- `busy` is registered (state ≠ IDLE).

## Structure
- Package `aftab_dawu_pkg` holds:
  - size encodings `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`;
  - state enum `dawu_state_t` {IDLE, WRITE};
  - function `size_bytes(sizeIn)`.
- Sub-module `aftab_dawu_lane_mask`: combinational; inputs `off`, `remR`, `dataR`; outputs `n`, `memByteEn`, `memDataOut`; parametrised by `MEM_BYTES`.
- The top level holds the FSM and the `addrR`, `dataR` and `remR` registers.

## Test plan
- **MEM_BYTES=4, aligned word:** addr 0x100, data 0xAABBCCDD, size 10, `memRdy`=1.
  - Expect one beat: `memAddr` 0x100, `memByteEn` 1111, data 0xAABBCCDD.
  - `completeDAWU` in cycle 1.
- **MEM_BYTES=4, misaligned half:** addr 0x103, data 0x1122, size 01.
  - Beat 1: addr 0x100, `memByteEn` 1000, lane 3 = 0x22.
  - Beat 2: addr 0x104, `memByteEn` 0001, lane 0 = 0x11.
  - `completeDAWU` in cycle 2.
- **MEM_BYTES=1, word:** addr 0x20, data 0x44332211.
  - Four beats to 0x20..0x23 with data 0x11, 0x22, 0x33, 0x44.
  - `memRdy` low for 2 cycles on beat 2: outputs hold, and `completeDAWU` moves to cycle 6.
- **ALLOW_MISALIGNED=0:** word store to 0x102.
  - `misaligned`=1 for one cycle; `writeMem` stays 0; `busy` stays 0.
- **Overlap/reset:** start again while busy → ignored, and the first store completes unchanged. Then `rst` after beat 1 of a 4-beat store → outputs 0 immediately, no further beats, and IDLE after release.
- **Wrap:** `MEM_BYTES`=4, addr 0xFFFFFFFE, word store.
  - Beats at 0xFFFFFFFC (`memByteEn` 1100) then 0x00000000 (`memByteEn` 0011).

Source files
------------

// File: rtl/aftab_dawu_pkg.sv
// rtl/aftab_dawu_pkg.sv - shared types and helpers for the multilane data-adjustment write unit
package aftab_dawu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } dawu_state_t;

  // Store size in bytes; the reserved encoding behaves as a word.
  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/aftab_dawu_lane_mask.sv
// rtl/aftab_dawu_lane_mask.sv - per-beat byte count, byte enables and lane steering
module aftab_dawu_lane_mask #(
  parameter int XLEN      = 32,
  parameter int MEM_BYTES = 4,
  parameter int OFF_W     = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1
) (
  input  logic [OFF_W-1:0]       off,
  input  logic [2:0]             remR,
  input  logic [XLEN-1:0]        dataR,
  output logic [2:0]             n,
  output logic [MEM_BYTES-1:0]   memByteEn,
  output logic [8*MEM_BYTES-1:0] memDataOut
);

  // Bytes that fit in this beat start at lane off; lane k carries byte k-off of the pending data.
  always_comb begin
    int off_i;
    int n_i;
    off_i      = (MEM_BYTES > 1) ? int'(off) : 0;
    n_i        = MEM_BYTES - off_i;
    if (int'(remR) < n_i) begin
      n_i = int'(remR);
    end
    n          = 3'(n_i);
    memByteEn  = '0;
    memDataOut = '0;
    for (int k = 0; k < MEM_BYTES; k++) begin
      if ((k >= off_i) && (k < off_i + n_i)) begin
        memByteEn[k]         = 1'b1;
        memDataOut[8*k +: 8] = dataR[8*(k-off_i) +: 8];
      end
    end
  end

endmodule

// File: rtl/aftab_dawu_multilane.sv
// rtl/aftab_dawu_multilane.sv - splits a core store into aligned memory beats with byte enables
module aftab_dawu_multilane
  import aftab_dawu_pkg::*;
#(
  parameter int XLEN             = 32,
  parameter int MEM_BYTES        = 4,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   startDAWU,
  input  logic [XLEN-1:0]        addrIn,
  input  logic [XLEN-1:0]        dataIn,
  input  logic [1:0]             sizeIn,
  input  logic                   memRdy,
  output logic [XLEN-1:0]        memAddr,
  output logic [8*MEM_BYTES-1:0] memDataOut,
  output logic [MEM_BYTES-1:0]   memByteEn,
  output logic                   writeMem,
  output logic                   busy,
  output logic                   completeDAWU,
  output logic                   misaligned
);

  localparam int OFF_W = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
  localparam logic [XLEN-1:0] LANE_MASK = XLEN'(MEM_BYTES - 1);

  dawu_state_t      state_q, state_d;
  logic [XLEN-1:0]  addr_q, addr_d;
  logic [XLEN-1:0]  data_q, data_d;
  logic [2:0]       rem_q, rem_d;
  logic             busy_q, busy_d;

  logic [OFF_W-1:0]       off;
  logic [2:0]             n;
  logic [MEM_BYTES-1:0]   lane_en;
  logic [8*MEM_BYTES-1:0] lane_data;
  logic [2:0]             req_bytes;
  logic                   req_unaligned;
  logic                   reject;
  logic                   accept;
  logic                   in_write;
  logic                   last_beat;

  assign off = OFF_W'(addr_q & LANE_MASK);

  aftab_dawu_lane_mask #(
    .XLEN      (XLEN),
    .MEM_BYTES (MEM_BYTES),
    .OFF_W     (OFF_W)
  ) u_lane_mask (
    .off        (off),
    .remR       (rem_q),
    .dataR      (data_q),
    .n          (n),
    .memByteEn  (lane_en),
    .memDataOut (lane_data)
  );

  // Request qualification, beat bookkeeping and next-state selection.
  always_comb begin
    in_write      = (state_q == WRITE);
    req_bytes     = size_bytes(sizeIn);
    req_unaligned = (addrIn & XLEN'(req_bytes - 3'd1)) != '0;
    reject        = startDAWU && !in_write && !ALLOW_MISALIGNED && req_unaligned;
    accept        = startDAWU && !in_write && !reject;
    last_beat     = (rem_q == n);

    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = WRITE;
          addr_d  = addrIn;
          data_d  = dataIn;
          rem_d   = req_bytes;
        end
      end
      WRITE: begin
        if (memRdy) begin
          addr_d = addr_q + XLEN'(n);
          data_d = data_q >> {n, 3'b000};
          rem_d  = rem_q - n;
          if (last_beat) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and store registers; reset aborts any store in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
    end
  end

  // Beat outputs are forced to zero outside WRITE so IDLE and reset read as all-zero.
  always_comb begin
    busy         = busy_q;
    writeMem     = in_write;
    completeDAWU = in_write && memRdy && last_beat;
    misaligned   = reject;
    memAddr      = in_write ? (addr_q & ~LANE_MASK) : '0;
    memByteEn    = in_write ? lane_en : '0;
    memDataOut   = in_write ? lane_data : '0;
  end

endmodule

// File: tb/tb_aftab_dawu_multilane.sv
// tb/tb_aftab_dawu_multilane.sv - directed and randomized bench for the multilane write unit
module tb_aftab_dawu_multilane;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // index 0: MEM_BYTES=4 split, 1: MEM_BYTES=1, 2: MEM_BYTES=4 trapping
  logic        start [3];
  logic [31:0] addr_i[3];
  logic [31:0] data_i[3];
  logic [1:0]  size_i[3];
  logic        rdy   [3];

  logic [31:0] a0, a1, a2, d0, d2;
  logic [7:0]  d1;
  logic [3:0]  e0, e2;
  logic [0:0]  e1;
  logic        w0, w1, w2, b0, b1, b2, c0, c1, c2, m0, m1, m2;

  logic [31:0] m_addr[3];
  logic [31:0] m_data[3];
  logic [3:0]  m_be  [3];
  logic        wr [3];
  logic        bsy[3];
  logic        cmp[3];
  logic        mis[3];

  always_comb begin
    m_addr[0] = a0;  m_addr[1] = a1;  m_addr[2] = a2;
    m_data[0] = d0;  m_data[1] = {24'h0, d1};  m_data[2] = d2;
    m_be[0]   = e0;  m_be[1]   = {3'b000, e1};  m_be[2]   = e2;
    wr[0]  = w0; wr[1]  = w1; wr[2]  = w2;
    bsy[0] = b0; bsy[1] = b1; bsy[2] = b2;
    cmp[0] = c0; cmp[1] = c1; cmp[2] = c2;
    mis[0] = m0; mis[1] = m1; mis[2] = m2;
  end

  aftab_dawu_multilane #(.XLEN(32), .MEM_BYTES(4), .ALLOW_MISALIGNED(1'b1)) u_w4 (
    .clk(clk), .rst(rst), .startDAWU(start[0]), .addrIn(addr_i[0]), .dataIn(data_i[0]),
    .sizeIn(size_i[0]), .memRdy(rdy[0]), .memAddr(a0), .memDataOut(d0), .memByteEn(e0),
    .writeMem(w0), .busy(b0), .completeDAWU(c0), .misaligned(m0));

  aftab_dawu_multilane #(.XLEN(32), .MEM_BYTES(1), .ALLOW_MISALIGNED(1'b1)) u_w1 (
    .clk(clk), .rst(rst), .startDAWU(start[1]), .addrIn(addr_i[1]), .dataIn(data_i[1]),
    .sizeIn(size_i[1]), .memRdy(rdy[1]), .memAddr(a1), .memDataOut(d1), .memByteEn(e1),
    .writeMem(w1), .busy(b1), .completeDAWU(c1), .misaligned(m1));

  aftab_dawu_multilane #(.XLEN(32), .MEM_BYTES(4), .ALLOW_MISALIGNED(1'b0)) u_trap (
    .clk(clk), .rst(rst), .startDAWU(start[2]), .addrIn(addr_i[2]), .dataIn(data_i[2]),
    .sizeIn(size_i[2]), .memRdy(rdy[2]), .memAddr(a2), .memDataOut(d2), .memByteEn(e2),
    .writeMem(w2), .busy(b2), .completeDAWU(c2), .misaligned(m2));

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference beats: walk the store byte by byte, group bytes that land in the same bus word.
  logic [31:0] exp_addr[4];
  logic [3:0]  exp_be  [4];
  logic [31:0] exp_dat [4];
  int          exp_nb;

  task automatic build_beats(input int mb, input logic [31:0] addr, input logic [31:0] data,
                             input int nbytes);
    logic [31:0] a;
    logic [31:0] word;
    int lane;
    exp_nb = 0;
    for (int i = 0; i < nbytes; i++) begin
      a    = addr + 32'(i);
      word = a & ~32'(mb - 1);
      lane = int'(a % 32'(mb));
      if (exp_nb == 0 || exp_addr[exp_nb-1] != word) begin
        exp_addr[exp_nb] = word;
        exp_be[exp_nb]   = 4'h0;
        exp_dat[exp_nb]  = 32'h0;
        exp_nb++;
      end
      exp_be[exp_nb-1]  = exp_be[exp_nb-1] | 4'(1 << lane);
      exp_dat[exp_nb-1] = exp_dat[exp_nb-1] | (((data >> (8*i)) & 32'hFF) << (8*lane));
    end
  endtask

  task automatic run_store(input int d, input logic [31:0] addr, input logic [31:0] data,
                           input logic [1:0] sz, input int stall_beat, input int stall_cyc,
                           input bit poke);
    int  mb;
    int  nbytes;
    bit  exp_mis;
    int  st;
    mb      = (d == 1) ? 1 : 4;
    nbytes  = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    exp_mis = (d == 2) && ((addr % 32'(nbytes)) != 0);
    build_beats(mb, addr, data, nbytes);

    @(negedge clk);
    start[d] = 1'b1; addr_i[d] = addr; data_i[d] = data; size_i[d] = sz; rdy[d] = 1'b1;
    #1;
    chk("start_misaligned", mis[d], exp_mis);
    chk("start_writeMem", wr[d], 0);
    chk("start_busy", bsy[d], 0);
    @(negedge clk);
    start[d] = 1'b0; addr_i[d] = $urandom; data_i[d] = $urandom;
    if (exp_mis) begin
      #1;
      chk("rej_writeMem", wr[d], 0);
      chk("rej_busy", bsy[d], 0);
      chk("rej_pulse_end", mis[d], 0);
      return;
    end
    for (int j = 0; j < exp_nb; j++) begin
      st = (j == stall_beat) ? stall_cyc : 0;
      for (int s = 0; s <= st; s++) begin
        rdy[d]   = (s == st);
        start[d] = poke && (j == 1) && (s == 0);
        #1;
        chk("beat_writeMem", wr[d], 1);
        chk("beat_busy", bsy[d], 1);
        chk("beat_addr", m_addr[d], exp_addr[j]);
        chk("beat_byteen", m_be[d], exp_be[j]);
        chk("beat_data", m_data[d], exp_dat[j]);
        chk("beat_complete", cmp[d], (s == st) && (j == exp_nb - 1));
        chk("beat_misaligned", mis[d], 0);
        @(negedge clk);
      end
    end
    start[d] = 1'b0; rdy[d] = 1'b1;
    #1;
    chk("end_writeMem", wr[d], 0);
    chk("end_busy", bsy[d], 0);
    chk("end_complete", cmp[d], 0);
    @(negedge clk);
    #1;
    chk("idle_writeMem", wr[d], 0);
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      start[d] = 1'b0; addr_i[d] = '0; data_i[d] = '0; size_i[d] = '0; rdy[d] = 1'b0;
    end
    #12;
    for (int d = 0; d < 3; d++) begin
      chk("rst_writeMem", wr[d], 0);
      chk("rst_busy", bsy[d], 0);
      chk("rst_complete", cmp[d], 0);
      chk("rst_misaligned", mis[d], 0);
      chk("rst_addr", m_addr[d], 0);
      chk("rst_data", m_data[d], 0);
      chk("rst_byteen", m_be[d], 0);
    end
    @(negedge clk);
    rst = 1'b0;

    run_store(0, 32'h0000_0100, 32'hAABB_CCDD, 2'b10, -1, 0, 1'b0);
    run_store(0, 32'h0000_0103, 32'h0000_1122, 2'b01, -1, 0, 1'b0);
    run_store(1, 32'h0000_0020, 32'h4433_2211, 2'b10, 1, 2, 1'b0);
    run_store(2, 32'h0000_0102, 32'h1234_5678, 2'b10, -1, 0, 1'b0);
    run_store(2, 32'h0000_0101, 32'h1234_5678, 2'b01, -1, 0, 1'b0);
    run_store(2, 32'h0000_0102, 32'h0000_BEEF, 2'b01, -1, 0, 1'b0);
    run_store(2, 32'h0000_0100, 32'hCAFE_F00D, 2'b11, -1, 0, 1'b0);
    run_store(1, 32'h0000_0030, 32'h8877_6655, 2'b10, -1, 0, 1'b1);
    run_store(0, 32'hFFFF_FFFE, 32'hDDCC_BBAA, 2'b10, -1, 0, 1'b0);

    // reset during the second beat of a four-beat store
    @(negedge clk);
    start[1] = 1'b1; addr_i[1] = 32'h40; data_i[1] = 32'hDEAD_BEEF; size_i[1] = 2'b10; rdy[1] = 1'b1;
    @(negedge clk);
    start[1] = 1'b0;
    #1;
    chk("rstmid_beat1", wr[1], 1);
    chk("rstmid_addr1", m_addr[1], 32'h40);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rstmid_writeMem", wr[1], 0);
    chk("rstmid_busy", bsy[1], 0);
    chk("rstmid_addr", m_addr[1], 0);
    chk("rstmid_data", m_data[1], 0);
    chk("rstmid_byteen", m_be[1], 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("post_rst_writeMem", wr[1], 0);
      chk("post_rst_busy", bsy[1], 0);
    end
    run_store(1, 32'h0000_0050, 32'h0000_00A5, 2'b00, -1, 0, 1'b0);

    for (int it = 0; it < 60; it++) begin
      run_store(int'($urandom_range(0, 2)), $urandom, $urandom, 2'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
